// File: rtl/msrv32_csr_pkg.sv
// Shared definitions for the RV32I machine-mode CSR file.
// Holds the 12-bit CSR address map, the Zicsr funct3 encodings, the misa
// value, the mstatus/mie bit positions and the read-modify-write helper
// used by the CSR file.
package msrv32_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // funct3 encodings; bit 2 selects the immediate form
  localparam logic [2:0] OP_RW  = 3'b001;
  localparam logic [2:0] OP_RS  = 3'b010;
  localparam logic [2:0] OP_RC  = 3'b011;
  localparam logic [2:0] OP_RWI = 3'b101;
  localparam logic [2:0] OP_RSI = 3'b110;
  localparam logic [2:0] OP_RCI = 3'b111;

  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MSIE     = 3;
  localparam int MIE_MTIE     = 7;
  localparam int MIE_MEIE     = 11;

  // Register and immediate forms share the low two funct3 bits.
  function automatic logic [31:0] csr_modify(input logic [1:0]  op,
                                             input logic [31:0] old_val,
                                             input logic [31:0] src);
    case (op)
      OP_RW[1:0]: csr_modify = src;
      OP_RS[1:0]: csr_modify = old_val | src;
      OP_RC[1:0]: csr_modify = old_val & ~src;
      default:    csr_modify = old_val;
    endcase
  endfunction

endpackage

// File: rtl/msrv32_csr_counter64.sv
// 64-bit machine counter (mcycle / minstret).
// Ports: clk_in, reset_in (sync, active-high), inc (count enable),
//        wr_lo / wr_hi (software write of the low / high word),
//        wr_data (write word), count (current 64-bit value).
// A software write to either word takes priority over the increment in the
// same cycle and the other word holds its value.
module msrv32_csr_counter64 (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wr_data,
  output logic [63:0] count
);

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      count <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) count[31:0]  <= wr_data;
      if (wr_hi) count[63:32] <= wr_data;
    end else if (inc) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/msrv32_machine_csr.sv
// Machine-mode CSR file for the RV32I core.
// Serves Zicsr accesses, records trap state requested by machine control,
// and returns interrupt enables/pendings, mepc and the trap vector target.
// Ports:
//   clk_in, reset_in               clock, synchronous active-high reset
//   wr_en_in, csr_addr_in,
//   csr_op_in, rs1_in, zimm_in     Zicsr access of the executing instruction
//   pc_in, iadder_in               trap PC and faulting address
//   i_or_e_in .. cause_in          trap/return strobes from machine control
//   e/t/s_irq_in                   interrupt lines (sampled into mip)
//   csr_data_out, illegal_csr_out  pre-write read data, illegal access flag
//   mie_out .. msip_out            interrupt state to machine control
//   epc_out, trap_address_out      mepc and trap vector target
// Build option: define MSRV32_USER_COUNTERS_EN to provide read-only user
// aliases cycle/instret/cycleh/instreth (C00/C02/C80/C82).
module msrv32_machine_csr
  import msrv32_csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'd0
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        wr_en_in,
  input  logic [11:0] csr_addr_in,
  input  logic [2:0]  csr_op_in,
  input  logic [31:0] rs1_in,
  input  logic [4:0]  zimm_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] iadder_in,
  input  logic        i_or_e_in,
  input  logic        set_cause_in,
  input  logic        set_epc_in,
  input  logic        instret_inc_in,
  input  logic        mie_clear_in,
  input  logic        mie_set_in,
  input  logic        misaligned_exception_in,
  input  logic [3:0]  cause_in,
  input  logic        e_irq_in,
  input  logic        t_irq_in,
  input  logic        s_irq_in,
  output logic [31:0] csr_data_out,
  output logic        illegal_csr_out,
  output logic        mie_out,
  output logic        meie_out,
  output logic        mtie_out,
  output logic        msie_out,
  output logic        meip_out,
  output logic        mtip_out,
  output logic        msip_out,
  output logic [31:0] epc_out,
  output logic [31:0] trap_address_out
);

  logic        mstatus_mie, mstatus_mpie;
  logic        meie, mtie, msie;
  logic        meip, mtip, msip;
  logic [31:0] mtvec, mscratch, mepc, mcause, mtval;
  logic [63:0] mcycle, minstret;

  logic [31:0] rdata, src, wdata, trap_base;
  logic        addr_ok, read_only, wr_ok;

  always_comb begin
    rdata     = '0;
    addr_ok   = 1'b1;
    read_only = 1'b0;
    case (csr_addr_in)
      // MPP is hardwired to machine mode (bits 12:11)
      CSR_MSTATUS:   rdata = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
      CSR_MISA:      begin rdata = MISA_VALUE; read_only = 1'b1; end
      CSR_MIE:       rdata = {20'b0, meie, 3'b0, mtie, 3'b0, msie, 3'b0};
      CSR_MTVEC:     rdata = mtvec;
      CSR_MSCRATCH:  rdata = mscratch;
      CSR_MEPC:      rdata = mepc;
      CSR_MCAUSE:    rdata = mcause;
      CSR_MTVAL:     rdata = mtval;
      CSR_MIP:       rdata = {20'b0, meip, 3'b0, mtip, 3'b0, msip, 3'b0};
      CSR_MCYCLE:    rdata = mcycle[31:0];
      CSR_MCYCLEH:   rdata = mcycle[63:32];
      CSR_MINSTRET:  rdata = minstret[31:0];
      CSR_MINSTRETH: rdata = minstret[63:32];
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: read_only = 1'b1;
      CSR_MHARTID:   begin rdata = HART_ID; read_only = 1'b1; end
`ifdef MSRV32_USER_COUNTERS_EN
      CSR_CYCLE:     begin rdata = mcycle[31:0];    read_only = 1'b1; end
      CSR_CYCLEH:    begin rdata = mcycle[63:32];   read_only = 1'b1; end
      CSR_INSTRET:   begin rdata = minstret[31:0];  read_only = 1'b1; end
      CSR_INSTRETH:  begin rdata = minstret[63:32]; read_only = 1'b1; end
`endif
      default:       addr_ok = 1'b0;
    endcase
  end

  assign csr_data_out    = rdata;
  assign illegal_csr_out = !addr_ok || (wr_en_in && read_only);

  assign src   = csr_op_in[2] ? {27'b0, zimm_in} : rs1_in;
  assign wdata = csr_modify(csr_op_in[1:0], rdata, src);
  // mip is accepted as a write target but has no writable state
  assign wr_ok = wr_en_in && addr_ok && !read_only && (csr_op_in[1:0] != 2'b00);

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      meie         <= 1'b0;
      mtie         <= 1'b0;
      msie         <= 1'b0;
      meip         <= 1'b0;
      mtip         <= 1'b0;
      msip         <= 1'b0;
      mtvec        <= MTVEC_RESET;
      mscratch     <= '0;
      mepc         <= '0;
      mcause       <= '0;
      mtval        <= '0;
    end else begin
      // trap entry beats mret, both beat a software write
      if (mie_clear_in) begin
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (mie_set_in) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (wr_ok && csr_addr_in == CSR_MSTATUS) begin
        mstatus_mie  <= wdata[MSTATUS_MIE];
        mstatus_mpie <= wdata[MSTATUS_MPIE];
      end

      if (wr_ok && csr_addr_in == CSR_MIE) begin
        meie <= wdata[MIE_MEIE];
        mtie <= wdata[MIE_MTIE];
        msie <= wdata[MIE_MSIE];
      end

      if (wr_ok && csr_addr_in == CSR_MTVEC)    mtvec    <= {wdata[31:2], 1'b0, wdata[0]};
      if (wr_ok && csr_addr_in == CSR_MSCRATCH) mscratch <= wdata;

      if (set_epc_in)                           mepc <= pc_in;
      else if (wr_ok && csr_addr_in == CSR_MEPC) mepc <= {wdata[31:2], 2'b00};

      if (set_cause_in) begin
        mcause <= {i_or_e_in, 27'b0, cause_in};
        mtval  <= misaligned_exception_in ? iadder_in : 32'd0;
      end else begin
        if (wr_ok && csr_addr_in == CSR_MCAUSE) mcause <= wdata;
        if (wr_ok && csr_addr_in == CSR_MTVAL)  mtval  <= wdata;
      end

      meip <= e_irq_in;
      mtip <= t_irq_in;
      msip <= s_irq_in;
    end
  end

  msrv32_csr_counter64 u_mcycle (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .inc      (1'b1),
    .wr_lo    (wr_ok && csr_addr_in == CSR_MCYCLE),
    .wr_hi    (wr_ok && csr_addr_in == CSR_MCYCLEH),
    .wr_data  (wdata),
    .count    (mcycle)
  );

  msrv32_csr_counter64 u_minstret (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .inc      (instret_inc_in),
    .wr_lo    (wr_ok && csr_addr_in == CSR_MINSTRET),
    .wr_hi    (wr_ok && csr_addr_in == CSR_MINSTRETH),
    .wr_data  (wdata),
    .count    (minstret)
  );

  // vectored mode applies to interrupts only: base + 4*cause
  assign trap_base        = {mtvec[31:2], 2'b00};
  assign trap_address_out = (mtvec[0] && i_or_e_in) ? trap_base + {26'b0, cause_in, 2'b00}
                                                    : trap_base;

  assign epc_out  = mepc;
  assign mie_out  = mstatus_mie;
  assign meie_out = meie;
  assign mtie_out = mtie;
  assign msie_out = msie;
  assign meip_out = meip;
  assign mtip_out = mtip;
  assign msip_out = msip;

endmodule

// File: tb/tb_msrv32_machine_csr.sv
// Testbench for msrv32_machine_csr: directed scenarios followed by random
// traffic, all compared against a behavioural model of the CSR file.
module tb_msrv32_machine_csr;

  localparam logic [31:0] MTVEC_RST = 32'h0000_0200;
  localparam logic [31:0] HART      = 32'd3;

  localparam logic [11:0] ADDR_TAB [0:21] = '{
    12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
    12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC02, 12'hC80,
    12'hC82, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7C0};
  localparam logic [2:0] OP_TAB [0:5] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

  logic        clk = 1'b0;
  logic        reset_in, wr_en_in;
  logic [11:0] csr_addr_in;
  logic [2:0]  csr_op_in;
  logic [31:0] rs1_in, pc_in, iadder_in;
  logic [4:0]  zimm_in;
  logic        i_or_e_in, set_cause_in, set_epc_in, instret_inc_in;
  logic        mie_clear_in, mie_set_in, misaligned_exception_in;
  logic [3:0]  cause_in;
  logic        e_irq_in, t_irq_in, s_irq_in;
  logic [31:0] csr_data_out, epc_out, trap_address_out;
  logic        illegal_csr_out, mie_out, meie_out, mtie_out, msie_out;
  logic        meip_out, mtip_out, msip_out;

  int n_checks = 0;
  int n_fail   = 0;

  // reference state
  bit          ref_mie, ref_mpie;
  logic [31:0] ref_ie, ref_ip, ref_tvec, ref_scratch, ref_epc, ref_cause, ref_tval;
  logic [63:0] ref_cyc, ref_ret;

  always #5 clk = ~clk;

  msrv32_machine_csr #(.MTVEC_RESET(MTVEC_RST), .HART_ID(HART)) dut (
    .clk_in                  (clk),
    .reset_in                (reset_in),
    .wr_en_in                (wr_en_in),
    .csr_addr_in             (csr_addr_in),
    .csr_op_in               (csr_op_in),
    .rs1_in                  (rs1_in),
    .zimm_in                 (zimm_in),
    .pc_in                   (pc_in),
    .iadder_in               (iadder_in),
    .i_or_e_in               (i_or_e_in),
    .set_cause_in            (set_cause_in),
    .set_epc_in              (set_epc_in),
    .instret_inc_in          (instret_inc_in),
    .mie_clear_in            (mie_clear_in),
    .mie_set_in              (mie_set_in),
    .misaligned_exception_in (misaligned_exception_in),
    .cause_in                (cause_in),
    .e_irq_in                (e_irq_in),
    .t_irq_in                (t_irq_in),
    .s_irq_in                (s_irq_in),
    .csr_data_out            (csr_data_out),
    .illegal_csr_out         (illegal_csr_out),
    .mie_out                 (mie_out),
    .meie_out                (meie_out),
    .mtie_out                (mtie_out),
    .msie_out                (msie_out),
    .meip_out                (meip_out),
    .mtip_out                (mtip_out),
    .msip_out                (msip_out),
    .epc_out                 (epc_out),
    .trap_address_out        (trap_address_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Architectural view of a CSR read.
  function automatic void ref_read(input logic [11:0] a, output logic [31:0] v,
                                   output bit known, output bit ro);
    known = 1'b1;
    ro    = 1'b0;
    v     = 32'd0;
    case (a)
      12'h300: v = 32'h1800 + (ref_mpie ? 32'h80 : 32'h0) + (ref_mie ? 32'h8 : 32'h0);
      12'h301: begin v = 32'h4000_0100; ro = 1'b1; end
      12'h304: v = ref_ie;
      12'h305: v = ref_tvec;
      12'h340: v = ref_scratch;
      12'h341: v = ref_epc;
      12'h342: v = ref_cause;
      12'h343: v = ref_tval;
      12'h344: v = ref_ip;
      12'hB00: v = ref_cyc[31:0];
      12'hB80: v = ref_cyc[63:32];
      12'hB02: v = ref_ret[31:0];
      12'hB82: v = ref_ret[63:32];
      12'hF11, 12'hF12, 12'hF13: ro = 1'b1;
      12'hF14: begin v = HART; ro = 1'b1; end
`ifdef MSRV32_USER_COUNTERS_EN
      12'hC00: begin v = ref_cyc[31:0];  ro = 1'b1; end
      12'hC80: begin v = ref_cyc[63:32]; ro = 1'b1; end
      12'hC02: begin v = ref_ret[31:0];  ro = 1'b1; end
      12'hC82: begin v = ref_ret[63:32]; ro = 1'b1; end
`endif
      default: known = 1'b0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic ref_step();
    logic [31:0] old_v, src, nv;
    logic [63:0] n_cyc, n_ret;
    bit known, ro, w, p_mie, p_mpie;
    if (reset_in) begin
      ref_mie = 0; ref_mpie = 0; ref_ie = 0; ref_ip = 0; ref_tvec = MTVEC_RST;
      ref_scratch = 0; ref_epc = 0; ref_cause = 0; ref_tval = 0; ref_cyc = 0; ref_ret = 0;
      return;
    end
    ref_read(csr_addr_in, old_v, known, ro);
    src = csr_op_in[2] ? 32'(zimm_in) : rs1_in;
    case (csr_op_in[1:0])
      2'd1:    nv = src;
      2'd2:    nv = old_v | src;
      2'd3:    nv = old_v & ~src;
      default: nv = old_v;
    endcase
    w      = wr_en_in && known && !ro && (csr_op_in[1:0] != 2'd0);
    n_cyc  = ref_cyc + 64'd1;
    n_ret  = ref_ret + (instret_inc_in ? 64'd1 : 64'd0);
    p_mie  = ref_mie;
    p_mpie = ref_mpie;
    if (w) begin
      case (csr_addr_in)
        12'h300: begin ref_mie = nv[3]; ref_mpie = nv[7]; end
        12'h304: ref_ie      = nv & 32'h0000_0888;
        12'h305: ref_tvec    = nv & ~32'h2;
        12'h340: ref_scratch = nv;
        12'h341: ref_epc     = nv & ~32'h3;
        12'h342: ref_cause   = nv;
        12'h343: ref_tval    = nv;
        12'hB00: n_cyc = {ref_cyc[63:32], nv};
        12'hB80: n_cyc = {nv, ref_cyc[31:0]};
        12'hB02: n_ret = {ref_ret[63:32], nv};
        12'hB82: n_ret = {nv, ref_ret[31:0]};
        default: ;
      endcase
    end
    if (mie_clear_in) begin
      ref_mpie = p_mie;
      ref_mie  = 1'b0;
    end else if (mie_set_in) begin
      ref_mie  = p_mpie;
      ref_mpie = 1'b1;
    end
    if (set_epc_in) ref_epc = pc_in;
    if (set_cause_in) begin
      ref_cause = (i_or_e_in ? 32'h8000_0000 : 32'h0) + 32'(cause_in);
      ref_tval  = misaligned_exception_in ? iadder_in : 32'd0;
    end
    ref_ip  = (e_irq_in ? 32'h800 : 32'h0) | (t_irq_in ? 32'h80 : 32'h0) | (s_irq_in ? 32'h8 : 32'h0);
    ref_cyc = n_cyc;
    ref_ret = n_ret;
  endtask

  task automatic compare_all();
    logic [31:0] v, base, trap;
    bit known, ro;
    ref_read(csr_addr_in, v, known, ro);
    base = ref_tvec & ~32'h3;
    trap = (ref_tvec[0] && i_or_e_in) ? base + 32'(cause_in) * 4 : base;
    check_eq("rdata",   csr_data_out, known ? v : 32'd0);
    check_eq("illegal", 32'(illegal_csr_out), 32'(!known || (wr_en_in && ro)));
    check_eq("epc",     epc_out, ref_epc);
    check_eq("trap",    trap_address_out, trap);
    check_eq("mie",     32'(mie_out),  32'(ref_mie));
    check_eq("meie",    32'(meie_out), 32'(ref_ie[11]));
    check_eq("mtie",    32'(mtie_out), 32'(ref_ie[7]));
    check_eq("msie",    32'(msie_out), 32'(ref_ie[3]));
    check_eq("meip",    32'(meip_out), 32'(ref_ip[11]));
    check_eq("mtip",    32'(mtip_out), 32'(ref_ip[7]));
    check_eq("msip",    32'(msip_out), 32'(ref_ip[3]));
  endtask

  // Called just after a falling edge with inputs applied.
  task automatic tick(input bit do_check);
    #1;
    if (do_check) compare_all();
    @(posedge clk);
    ref_step();
    @(negedge clk);
  endtask

  task automatic quiet();
    wr_en_in = 0; csr_op_in = 3'b001; rs1_in = 0; zimm_in = 0; pc_in = 0; iadder_in = 0;
    i_or_e_in = 0; set_cause_in = 0; set_epc_in = 0; instret_inc_in = 0;
    mie_clear_in = 0; mie_set_in = 0; misaligned_exception_in = 0; cause_in = 0;
    e_irq_in = 0; t_irq_in = 0; s_irq_in = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    quiet();
    reset_in    = 1;
    csr_addr_in = 12'h300;
    @(negedge clk);
    tick(0);
    tick(1);
    reset_in = 0;

    // reset values
    csr_addr_in = 12'h301; #1 check_eq("misa", csr_data_out, 32'h4000_0100);
    csr_addr_in = 12'h305; #1 check_eq("mtvec_rst", csr_data_out, MTVEC_RST);
    csr_addr_in = 12'h300; #1 check_eq("mstatus_rst", csr_data_out, 32'h0000_1800);
    tick(1);

    // mscratch RW then RCI
    csr_addr_in = 12'h340; csr_op_in = 3'b001; rs1_in = 32'hDEAD_BEEF; wr_en_in = 1;
    #1 check_eq("rw_old", csr_data_out, 32'h0);
    tick(1);
    wr_en_in = 0;
    #1 check_eq("rw_new", csr_data_out, 32'hDEAD_BEEF);
    csr_op_in = 3'b111; zimm_in = 5'h0F; wr_en_in = 1;
    tick(1);
    wr_en_in = 0;
    #1 check_eq("rci", csr_data_out, 32'hDEAD_BEE0);
    tick(1);

    // MIE set, trap entry, mret
    csr_addr_in = 12'h300; csr_op_in = 3'b110; zimm_in = 5'd8; wr_en_in = 1;
    tick(1);
    wr_en_in = 0;
    #1 check_eq("mie_set_sw", 32'(mie_out), 32'd1);
    mie_clear_in = 1; set_epc_in = 1; pc_in = 32'h0000_0100;
    tick(1);
    mie_clear_in = 0; set_epc_in = 0;
    #1 check_eq("trap_mstatus", csr_data_out, 32'h0000_1880);
    check_eq("trap_mie", 32'(mie_out), 32'd0);
    check_eq("trap_epc", epc_out, 32'h0000_0100);
    mie_set_in = 1;
    tick(1);
    mie_set_in = 0;
    #1 check_eq("mret_mstatus", csr_data_out, 32'h0000_1888);
    check_eq("mret_mie", 32'(mie_out), 32'd1);
    tick(1);

    // vectored trap address
    csr_addr_in = 12'h305; csr_op_in = 3'b001; rs1_in = 32'h0000_1001; wr_en_in = 1;
    tick(1);
    wr_en_in = 0; i_or_e_in = 1; cause_in = 4'd7; set_cause_in = 1;
    #1 check_eq("trap_vec", trap_address_out, 32'h0000_101C);
    tick(1);
    set_cause_in = 0; csr_addr_in = 12'h342;
    #1 check_eq("mcause", csr_data_out, 32'h8000_0007);
    i_or_e_in = 0;
    #1 check_eq("trap_direct", trap_address_out, 32'h0000_1000);
    tick(1);

    // counter wrap and instret
    csr_addr_in = 12'hB00; csr_op_in = 3'b001; rs1_in = 32'hFFFF_FFFF; wr_en_in = 1;
    tick(1);
    csr_addr_in = 12'hB80;
    tick(1);
    wr_en_in = 0;
    tick(1);
    tick(1);
    csr_addr_in = 12'hB00; #1 check_eq("mcycle_lo", csr_data_out, 32'd1);
    csr_addr_in = 12'hB80; #1 check_eq("mcycle_hi", csr_data_out, 32'd0);
    instret_inc_in = 1;
    tick(1); tick(1); tick(1);
    instret_inc_in = 0;
    csr_addr_in = 12'hB02; #1 check_eq("minstret", csr_data_out, 32'd3);
    tick(1);

    // unimplemented, optional user counters, read-only write
    csr_addr_in = 12'h7C0;
    #1 check_eq("unimpl_data", csr_data_out, 32'd0);
    check_eq("unimpl_illegal", 32'(illegal_csr_out), 32'd1);
    csr_addr_in = 12'hC00;
`ifdef MSRV32_USER_COUNTERS_EN
    #1 check_eq("cycle_alias", csr_data_out, ref_cyc[31:0]);
    check_eq("cycle_alias_ok", 32'(illegal_csr_out), 32'd0);
`else
    #1 check_eq("cycle_alias_illegal", 32'(illegal_csr_out), 32'd1);
    check_eq("cycle_alias_data", csr_data_out, 32'd0);
`endif
    csr_addr_in = 12'h301; wr_en_in = 1; csr_op_in = 3'b001; rs1_in = 32'h1234_5678;
    #1 check_eq("misa_wr_illegal", 32'(illegal_csr_out), 32'd1);
    tick(1);
    wr_en_in = 0;
    tick(1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      reset_in    = ($urandom_range(0, 149) == 0);
      wr_en_in    = $urandom_range(0, 1) == 1;
      csr_addr_in = ($urandom_range(0, 15) == 0) ? 12'($urandom) : ADDR_TAB[$urandom_range(0, 21)];
      csr_op_in   = OP_TAB[$urandom_range(0, 5)];
      rs1_in      = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      zimm_in     = 5'($urandom);
      pc_in       = $urandom & ~32'h3;
      iadder_in   = $urandom;
      i_or_e_in   = $urandom_range(0, 1) == 1;
      cause_in    = 4'($urandom);
      set_cause_in = ($urandom_range(0, 7) == 0);
      set_epc_in   = ($urandom_range(0, 7) == 0);
      mie_clear_in = ($urandom_range(0, 7) == 0);
      mie_set_in   = ($urandom_range(0, 7) == 0);
      misaligned_exception_in = $urandom_range(0, 1) == 1;
      instret_inc_in = $urandom_range(0, 1) == 1;
      e_irq_in = $urandom_range(0, 1) == 1;
      t_irq_in = $urandom_range(0, 1) == 1;
      s_irq_in = $urandom_range(0, 1) == 1;
      tick(1);
    end
    reset_in = 0;
    quiet();
    tick(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
